// File: rtl/decode_pipe_if.sv
// Fetch -> decode -> execute bundle plus writeback port for decode_pipe.
// The slave modport is the decode stage; the master modport is its environment.
interface decode_pipe_if #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 16
);
    // A beat moves on a clock edge exactly when valid and ready are both high;
    // valid never waits on ready, and a producer keeps its data stable until the beat moves.
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_instr;
    logic [PC_W-1:0]   in_pc;
    logic              flush;

    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_instr;
    logic [PC_W-1:0]   out_pc;
    logic [DATA_W-1:0] out_rs_data;
    logic [DATA_W-1:0] out_rt_data;
    logic [DATA_W-1:0] out_imm;
    logic [2:0]        out_wr_reg;
    logic              out_reg_wrt;
    logic              out_mem_wrt;
    logic              out_mem_rd;
    logic              out_halt;

    logic              wb_wr_en;
    logic [2:0]        wb_wr_reg;
    logic [DATA_W-1:0] wb_wr_data;

    logic              halted;

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
               wb_wr_en, wb_wr_reg, wb_wr_data,
        output in_ready, out_valid, out_instr, out_pc, out_rs_data, out_rt_data,
               out_imm, out_wr_reg, out_reg_wrt, out_mem_wrt, out_mem_rd, out_halt,
               halted
    );

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
               wb_wr_en, wb_wr_reg, wb_wr_data,
        input  in_ready, out_valid, out_instr, out_pc, out_rs_data, out_rt_data,
               out_imm, out_wr_reg, out_reg_wrt, out_mem_wrt, out_mem_rd, out_halt,
               halted
    );
endinterface

// File: rtl/decode_pipe.sv
// WISC-SP22 pipelined decode: register file, decoder and ID/EX register with hold snooping.
// Define DECODE_RF_BYPASS_EN to make the register-file read ports write-through.
module decode_pipe #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 16
) (
    input logic          clk,
    input logic          rst,
    decode_pipe_if.slave bus
);
    logic [DATA_W-1:0] rf_q [8];

    logic              out_valid_q,   out_valid_d;
    logic [15:0]       out_instr_q,   out_instr_d;
    logic [PC_W-1:0]   out_pc_q,      out_pc_d;
    logic [DATA_W-1:0] out_rs_data_q, out_rs_data_d;
    logic [DATA_W-1:0] out_rt_data_q, out_rt_data_d;
    logic [DATA_W-1:0] out_imm_q,     out_imm_d;
    logic [2:0]        out_wr_reg_q,  out_wr_reg_d;
    logic              out_reg_wrt_q, out_reg_wrt_d;
    logic              out_mem_wrt_q, out_mem_wrt_d;
    logic              out_mem_rd_q,  out_mem_rd_d;
    logic              out_halt_q,    out_halt_d;
    logic              halted_q,      halted_d;

    logic [4:0]        op;
    logic              in_ready;
    logic              accept;
    logic              dec_reg_wrt;
    logic [2:0]        dec_wr_reg;
    logic [DATA_W-1:0] dec_imm;
    logic [DATA_W-1:0] rs_rd;
    logic [DATA_W-1:0] rt_rd;

    assign op       = bus.in_instr[15:11];
    // A held HALT blocks fetch even when execute is ready, so nothing follows it.
    assign in_ready = ~halted_q & ~(out_valid_q & out_halt_q) & (~out_valid_q | bus.out_ready);
    assign accept   = bus.in_valid & in_ready & ~bus.flush;

    always_comb begin
        dec_reg_wrt = 1'b0;
        dec_wr_reg  = 3'd0;
        dec_imm     = '0;
        casez (op)
            5'b010??: begin
                dec_reg_wrt = 1'b1;
                dec_wr_reg  = bus.in_instr[7:5];
                dec_imm     = op[1] ? {{(DATA_W-5){1'b0}}, bus.in_instr[4:0]}
                                    : {{(DATA_W-5){bus.in_instr[4]}}, bus.in_instr[4:0]};
            end
            5'b101??, 5'b10001: begin
                dec_reg_wrt = 1'b1;
                dec_wr_reg  = bus.in_instr[7:5];
                dec_imm     = {{(DATA_W-5){bus.in_instr[4]}}, bus.in_instr[4:0]};
            end
            5'b10000: dec_imm = {{(DATA_W-5){bus.in_instr[4]}}, bus.in_instr[4:0]};
            5'b10011: begin
                dec_reg_wrt = 1'b1;
                dec_wr_reg  = bus.in_instr[10:8];
                dec_imm     = {{(DATA_W-5){bus.in_instr[4]}}, bus.in_instr[4:0]};
            end
            5'b011??, 5'b00101: dec_imm = {{(DATA_W-8){bus.in_instr[7]}}, bus.in_instr[7:0]};
            5'b11000: begin
                dec_reg_wrt = 1'b1;
                dec_wr_reg  = bus.in_instr[10:8];
                dec_imm     = {{(DATA_W-8){bus.in_instr[7]}}, bus.in_instr[7:0]};
            end
            5'b10010: begin
                dec_reg_wrt = 1'b1;
                dec_wr_reg  = bus.in_instr[10:8];
                dec_imm     = {{(DATA_W-8){1'b0}}, bus.in_instr[7:0]};
            end
            5'b00111: begin
                dec_reg_wrt = 1'b1;
                dec_wr_reg  = 3'd7;
                dec_imm     = {{(DATA_W-8){bus.in_instr[7]}}, bus.in_instr[7:0]};
            end
            5'b00100: dec_imm = {{(DATA_W-11){bus.in_instr[10]}}, bus.in_instr[10:0]};
            5'b00110: begin
                dec_reg_wrt = 1'b1;
                dec_wr_reg  = 3'd7;
                dec_imm     = {{(DATA_W-11){bus.in_instr[10]}}, bus.in_instr[10:0]};
            end
            5'b11001, 5'b1101?, 5'b111??: begin
                dec_reg_wrt = 1'b1;
                dec_wr_reg  = bus.in_instr[4:2];
            end
            default: ;
        endcase
    end

    always_comb begin
        rs_rd = rf_q[bus.in_instr[10:8]];
        rt_rd = rf_q[bus.in_instr[7:5]];
`ifdef DECODE_RF_BYPASS_EN
        if (bus.wb_wr_en && (bus.wb_wr_reg == bus.in_instr[10:8])) rs_rd = bus.wb_wr_data;
        if (bus.wb_wr_en && (bus.wb_wr_reg == bus.in_instr[7:5]))  rt_rd = bus.wb_wr_data;
`else
        // Without write-through, execute forwarding covers a same-cycle writeback.
`endif
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_instr_d   = out_instr_q;
        out_pc_d      = out_pc_q;
        out_rs_data_d = out_rs_data_q;
        out_rt_data_d = out_rt_data_q;
        out_imm_d     = out_imm_q;
        out_wr_reg_d  = out_wr_reg_q;
        out_reg_wrt_d = out_reg_wrt_q;
        out_mem_wrt_d = out_mem_wrt_q;
        out_mem_rd_d  = out_mem_rd_q;
        out_halt_d    = out_halt_q;
        halted_d      = halted_q | (out_valid_q & out_halt_q & bus.out_ready & ~bus.flush);
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d   = 1'b1;
            out_instr_d   = bus.in_instr;
            out_pc_d      = bus.in_pc;
            out_rs_data_d = rs_rd;
            out_rt_data_d = rt_rd;
            out_imm_d     = dec_imm;
            out_wr_reg_d  = dec_wr_reg;
            out_reg_wrt_d = dec_reg_wrt;
            out_mem_wrt_d = (op == 5'b10000) || (op == 5'b10011);
            out_mem_rd_d  = (op == 5'b10001);
            out_halt_d    = (op == 5'b00000);
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end else if (out_valid_q) begin
            // Stalled bundle tracks writebacks so its operands are current when execute takes it.
            if (bus.wb_wr_en && (bus.wb_wr_reg == out_instr_q[10:8])) out_rs_data_d = bus.wb_wr_data;
            if (bus.wb_wr_en && (bus.wb_wr_reg == out_instr_q[7:5]))  out_rt_data_d = bus.wb_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
            out_valid_q   <= 1'b0;
            out_instr_q   <= '0;
            out_pc_q      <= '0;
            out_rs_data_q <= '0;
            out_rt_data_q <= '0;
            out_imm_q     <= '0;
            out_wr_reg_q  <= '0;
            out_reg_wrt_q <= 1'b0;
            out_mem_wrt_q <= 1'b0;
            out_mem_rd_q  <= 1'b0;
            out_halt_q    <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            if (bus.wb_wr_en) rf_q[bus.wb_wr_reg] <= bus.wb_wr_data;
            out_valid_q   <= out_valid_d;
            out_instr_q   <= out_instr_d;
            out_pc_q      <= out_pc_d;
            out_rs_data_q <= out_rs_data_d;
            out_rt_data_q <= out_rt_data_d;
            out_imm_q     <= out_imm_d;
            out_wr_reg_q  <= out_wr_reg_d;
            out_reg_wrt_q <= out_reg_wrt_d;
            out_mem_wrt_q <= out_mem_wrt_d;
            out_mem_rd_q  <= out_mem_rd_d;
            out_halt_q    <= out_halt_d;
            halted_q      <= halted_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_instr   = out_instr_q;
    assign bus.out_pc      = out_pc_q;
    assign bus.out_rs_data = out_rs_data_q;
    assign bus.out_rt_data = out_rt_data_q;
    assign bus.out_imm     = out_imm_q;
    assign bus.out_wr_reg  = out_wr_reg_q;
    assign bus.out_reg_wrt = out_reg_wrt_q;
    assign bus.out_mem_wrt = out_mem_wrt_q;
    assign bus.out_mem_rd  = out_mem_rd_q;
    assign bus.out_halt    = out_halt_q;
    assign bus.halted      = halted_q;
endmodule

// File: tb/tb_decode_pipe.sv
// Scoreboard bench for decode_pipe: directed scenarios followed by randomized traffic.
module tb_decode_pipe;
    localparam int DW = 16;
    localparam int PW = 16;
    localparam int BW = 87;
    localparam int RS_LO = 39;
    localparam int RT_LO = 23;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_pipe_if #(.DATA_W(DW), .PC_W(PW)) bus ();
    decode_pipe #(.DATA_W(DW), .PC_W(PW)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [BW-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] m_rf [8];
    bit            m_valid  = 0;
    bit            m_halt   = 0;
    bit            m_halted = 0;
    logic [2:0]    m_rs_idx = 0;
    logic [2:0]    m_rt_idx = 0;

    function automatic logic [BW-1:0] pack(logic [15:0] instr, logic [PW-1:0] pc, logic [DW-1:0] rs,
                                          logic [DW-1:0] rt, logic [DW-1:0] imm, logic [2:0] wr_reg,
                                          logic reg_wrt, logic mem_wrt, logic mem_rd, logic halt);
        return {instr, pc, rs, rt, imm, wr_reg, reg_wrt, mem_wrt, mem_rd, halt};
    endfunction

    function automatic bit f_reg_wrt(logic [4:0] op);
        return op inside {[5'd8:5'd11], [5'd20:5'd23], 5'd17, 5'd19, 5'd24, 5'd18,
                          [5'd25:5'd31], 5'd6, 5'd7};
    endfunction

    function automatic logic [2:0] f_wr_reg(logic [15:0] ins);
        logic [4:0] op = ins[15:11];
        if (op inside {[5'd25:5'd31]}) return ins[4:2];
        if (op inside {[5'd8:5'd11], [5'd20:5'd23], 5'd17}) return ins[7:5];
        if (op inside {5'd24, 5'd18, 5'd19}) return ins[10:8];
        if (op inside {5'd6, 5'd7}) return 3'd7;
        return 3'd0;
    endfunction

    function automatic logic [DW-1:0] f_imm(logic [15:0] ins);
        logic [4:0] op = ins[15:11];
        int v = 0;
        if (op inside {[5'd8:5'd11], [5'd20:5'd23], 5'd16, 5'd17, 5'd19}) begin
            v = int'(ins[4:0]);
            if (!(op inside {5'd10, 5'd11}) && v >= 16) v -= 32;
        end else if (op inside {[5'd12:5'd15], 5'd24, 5'd18, 5'd5, 5'd7}) begin
            v = int'(ins[7:0]);
            if (op != 5'd18 && v >= 128) v -= 256;
        end else if (op inside {5'd4, 5'd6}) begin
            v = int'(ins[10:0]);
            if (v >= 1024) v -= 2048;
        end
        return DW'(v);
    endfunction

    function automatic bit m_ready();
        return !m_halted && !(m_valid && m_halt) && (!m_valid || bus.out_ready);
    endfunction

    task automatic check(string name, logic [BW-1:0] act, logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: register file, one pending bundle, sticky halt.
    initial begin
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        forever begin
            logic [BW-1:0] e;
            logic [15:0]   ins;
            logic [DW-1:0] rs, rt;
            bit            acc;
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int i = 0; i < 8; i++) m_rf[i] = '0;
                m_valid = 0; m_halt = 0; m_halted = 0;
                exp_q.delete();
            end else begin
                acc = bus.in_valid && m_ready() && !bus.flush;
                if (m_valid && m_halt && bus.out_ready && !bus.flush) m_halted = 1;
                if (bus.flush) begin
                    if (m_valid && exp_q.size() > 0) void'(exp_q.pop_back());
                    m_valid = 0;
                end else if (acc) begin
                    ins = bus.in_instr;
                    rs = m_rf[ins[10:8]];
                    rt = m_rf[ins[7:5]];
`ifdef DECODE_RF_BYPASS_EN
                    if (bus.wb_wr_en && bus.wb_wr_reg == ins[10:8]) rs = bus.wb_wr_data;
                    if (bus.wb_wr_en && bus.wb_wr_reg == ins[7:5])  rt = bus.wb_wr_data;
`endif
                    exp_q.push_back(pack(ins, bus.in_pc, rs, rt, f_imm(ins), f_wr_reg(ins),
                                         f_reg_wrt(ins[15:11]), ins[15:11] inside {5'd16, 5'd19},
                                         ins[15:11] == 5'd17, ins[15:11] == 5'd0));
                    m_valid = 1; m_halt = (ins[15:11] == 5'd0);
                    m_rs_idx = ins[10:8]; m_rt_idx = ins[7:5];
                end else if (m_valid && bus.out_ready) begin
                    m_valid = 0;
                end else if (m_valid && bus.wb_wr_en && exp_q.size() > 0) begin
                    e = exp_q.pop_back();
                    if (bus.wb_wr_reg == m_rs_idx) e[RS_LO +: DW] = bus.wb_wr_data;
                    if (bus.wb_wr_reg == m_rt_idx) e[RT_LO +: DW] = bus.wb_wr_data;
                    exp_q.push_back(e);
                end
                if (bus.wb_wr_en) m_rf[bus.wb_wr_reg] = bus.wb_wr_data;
            end
        end
    end

    // Monitor: handshake/status every cycle, full bundle whenever execute consumes one.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("in_ready", bus.in_ready, m_ready());
                check("out_valid", bus.out_valid, m_valid);
                check("halted", bus.halted, m_halted);
                if (bus.out_valid && bus.out_ready && !bus.flush) begin
                    if (exp_q.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL bundle: got %h expected none queued",
                                 pack(bus.out_instr, bus.out_pc, bus.out_rs_data, bus.out_rt_data,
                                      bus.out_imm, bus.out_wr_reg, bus.out_reg_wrt,
                                      bus.out_mem_wrt, bus.out_mem_rd, bus.out_halt));
                    end else begin
                        check("bundle", pack(bus.out_instr, bus.out_pc, bus.out_rs_data,
                                             bus.out_rt_data, bus.out_imm, bus.out_wr_reg,
                                             bus.out_reg_wrt, bus.out_mem_wrt, bus.out_mem_rd,
                                             bus.out_halt), exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 0; bus.in_instr = '0; bus.in_pc = '0; bus.flush = 0; bus.out_ready = 1;
        bus.wb_wr_en = 0; bus.wb_wr_reg = '0; bus.wb_wr_data = '0;
    endtask

    task automatic wb(logic [2:0] r, logic [DW-1:0] d);
        bus.wb_wr_en = 1; bus.wb_wr_reg = r; bus.wb_wr_data = d;
    endtask

    task automatic issue(logic [15:0] ins, logic [PW-1:0] pc);
        bus.in_valid = 1; bus.in_instr = ins; bus.in_pc = pc;
    endtask

    task automatic do_reset();
        rst = 1; step(); step(); rst = 0;
    endtask

    logic [15:0]   t5_ins [4] = '{16'h5010, 16'h9380, 16'h2400, 16'h3005};
    logic [DW-1:0] t5_imm [4] = '{16'h0010, 16'h0080, 16'hFC00, 16'h0005};
    logic [2:0]    t5_wr  [4] = '{3'd0, 3'd3, 3'd0, 3'd7};

    initial begin
        idle();
        step(); step();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_halted", bus.halted, 0);
        check("rst_rs_data", bus.out_rs_data, 0);
        check("rst_instr", bus.out_instr, 0);
        rst = 0;

        // ADDI R2,R1,-1 after writing R1
        wb(3'd1, 16'h1234); step();
        bus.wb_wr_en = 0; issue(16'h415F, 16'h0002); bus.out_ready = 0; step();
        bus.in_valid = 0;
        check("t1_valid", bus.out_valid, 1);
        check("t1_rs", bus.out_rs_data, 16'h1234);
        check("t1_imm", bus.out_imm, 16'hFFFF);
        check("t1_wr_reg", bus.out_wr_reg, 2);
        check("t1_reg_wrt", bus.out_reg_wrt, 1);

        // ADD R3,R1,R2 held while R1 is rewritten
        bus.out_ready = 1; issue(16'hD94C, 16'h0004); step();
        bus.out_ready = 0; issue(16'h4000, 16'h0006); wb(3'd1, 16'h00AA); step();
        bus.wb_wr_en = 0;
        check("t2_snoop", bus.out_rs_data, 16'h00AA);
        check("t2_in_ready", bus.in_ready, 0);
        check("t2_instr", bus.out_instr, 16'hD94C);
        check("t2_wr_reg", bus.out_wr_reg, 3);
        step();
        check("t2_hold_ready", bus.in_ready, 0);
        bus.out_ready = 1; #1;
        check("t2_release", bus.in_ready, 1);
        bus.out_ready = 0;

        // flush kills held bundle and incoming instruction
        bus.flush = 1; step();
        bus.flush = 0; bus.in_valid = 0;
        check("t3_valid", bus.out_valid, 0);
        step();
        check("t3_nocap", bus.out_valid, 0);

        // flushed HALT is discarded
        issue(16'h0000, 16'h0010); step();
        bus.in_valid = 0;
        check("fh_held", bus.out_halt, 1);
        check("fh_ready", bus.in_ready, 0);
        bus.flush = 1; step();
        bus.flush = 0;
        check("fh_halted", bus.halted, 0);
        check("fh_resume", bus.in_ready, 1);

        // HALT consumed -> sticky stall
        issue(16'h0000, 16'h0012); step();
        bus.out_ready = 1; issue(16'h4000, 16'h0014); #1;
        check("t4_ready_held", bus.in_ready, 0);
        step();
        check("t4_halted", bus.halted, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            check("t4_stall", bus.in_ready, 0);
        end
        idle();
        do_reset();

        // immediate extension corner cases
        for (int i = 0; i < 4; i++) begin
            issue(t5_ins[i], PW'(i)); step();
            check("t5_imm", bus.out_imm, t5_imm[i]);
            check("t5_wr_reg", bus.out_wr_reg, t5_wr[i]);
        end
        bus.in_valid = 0;

        // same-cycle writeback vs read of R4
        wb(3'd4, 16'h1111); step();
        wb(3'd4, 16'hBEEF); issue(16'hDC04, 16'h0020); step();
        bus.wb_wr_en = 0; bus.in_valid = 0;
`ifdef DECODE_RF_BYPASS_EN
        check("t6_bypass", bus.out_rs_data, 16'hBEEF);
`else
        check("t6_bypass", bus.out_rs_data, 16'h1111);
`endif

        // asynchronous reset with a live bundle
        issue(16'h415F, 16'h0030); step();
        bus.in_valid = 0; bus.out_ready = 0;
        #1 rst = 1;
        #1 check("mr_valid", bus.out_valid, 0);
        check("mr_halted", bus.halted, 0);
        step(); rst = 0; bus.out_ready = 1;

        for (int c = 0; c < 3000; c++) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_instr = 16'($urandom);
            if (bus.in_instr[15:11] == 5'd0 && $urandom_range(0, 7) != 0) bus.in_instr[15:11] = 5'd1;
            bus.in_pc = PW'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush = ($urandom_range(0, 15) == 0);
            bus.wb_wr_en = $urandom_range(0, 1);
            bus.wb_wr_reg = 3'($urandom_range(0, 7));
            bus.wb_wr_data = DW'($urandom);
            if (m_halted && $urandom_range(0, 7) == 0) do_reset();
            else step();
        end

        idle();
        step(); step(); step();
        check("drain_q", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
